// File: rtl/mux_select_sequencer.sv
// ---------------------------------------------------------------------------
// mux_select_sequencer
//
// Purpose:
//   Produces the 3-bit select code for the five-input character multiplexers.
//   The code steps through 0..LAST_CODE, either automatically every
//   DIV_MAX+1 clocks while running, or manually on each press of a raw
//   (unsynchronised, active-low) push-button. A synchronous load can place
//   any code directly; out-of-range load values are clamped to LAST_CODE.
//
// Ports:
//   clock     in   system clock, rising-edge active
//   resetn    in   asynchronous active-low reset
//   run       in   level: 1 = auto-advance (RUN), 0 = paused (PAUSE)
//   step_n    in   raw push-button, active-low, asynchronous to clock
//   dir       in   0 = count up, 1 = count down
//   load      in   synchronous load strobe, wins over any advance
//   load_val  in   [2:0] code to load (clamped to LAST_CODE)
//   sel       out  [2:0] current select code (registered)
//   tick      out  one-cycle pulse in the cycle after any advance
//   wrap      out  one-cycle pulse in the cycle after a wrapping advance
//   running   out  1 while the sequencer is in RUN
// ---------------------------------------------------------------------------
module mux_select_sequencer #(
    parameter int DIV_WIDTH = 26,
    parameter int DIV_MAX   = 49999999,
    parameter int LAST_CODE = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       run,
    input  logic       step_n,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic [2:0] sel,
    output logic       tick,
    output logic       wrap,
    output logic       running
);

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [2:0]           LAST     = 3'(LAST_CODE);
    localparam logic [DIV_WIDTH-1:0] DIV_TERM = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state_reg;
    logic [DIV_WIDTH-1:0] prescale_reg;
    logic [DIV_WIDTH-1:0] prescale_next;
    logic [2:0]           sync_reg;      // [0]=s1, [1]=s2, [2]=s3
    logic [2:0]           sel_reg;
    logic                 tick_reg;
    logic                 wrap_reg;
    logic                 running_reg;

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    logic       step_pulse;
    logic       auto_adv;
    logic       adv;
    logic       wrapped;
    logic [2:0] adv_sel;
    logic [2:0] load_sel;

    // Falling edge of the button seen at the end of the 3-flop chain:
    // s3 still holds the old high level while s2 already shows the low.
    assign step_pulse = sync_reg[2] & ~sync_reg[1];

    // The prescaler only ever reaches the terminal count while in RUN,
    // but qualifying with the state keeps the intent explicit.
    assign auto_adv = (state_reg == ST_RUN) && (prescale_reg == DIV_TERM);

    // A coincident button edge and terminal count merge into one advance.
    assign adv = step_pulse | auto_adv;

    assign load_sel = (load_val > LAST) ? LAST : load_val;

    // Next code for an advance. An illegal code (only reachable through an
    // upset) recovers to 0 regardless of direction and does not count as a wrap.
    always_comb begin
        adv_sel = 3'd0;
        wrapped = 1'b0;
        if (sel_reg > LAST) begin
            adv_sel = 3'd0;
            wrapped = 1'b0;
        end else if (!dir) begin
            if (sel_reg == LAST) begin
                adv_sel = 3'd0;
                wrapped = 1'b1;
            end else begin
                adv_sel = sel_reg + 3'd1;
            end
        end else begin
            if (sel_reg == 3'd0) begin
                adv_sel = LAST;
                wrapped = 1'b1;
            end else begin
                adv_sel = sel_reg - 3'd1;
            end
        end
    end

    // Prescaler: counts only while staying in RUN. Entering RUN starts from
    // 0 (it was held there in PAUSE), so the first auto-advance lands
    // DIV_MAX+1 clocks after the transition edge. Dropping run clears it on
    // the same edge that leaves RUN. A load restarts the interval.
    always_comb begin
        prescale_next = '0;
        if (load) begin
            prescale_next = '0;
        end else if ((state_reg == ST_RUN) && run) begin
            if (prescale_reg == DIV_TERM) begin
                prescale_next = '0;
            end else begin
                prescale_next = prescale_reg + DIV_ONE;
            end
        end else begin
            prescale_next = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential: FSM, synchroniser, prescaler, select code, status pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_PAUSE;
            running_reg  <= 1'b0;
            prescale_reg <= '0;
            // Idle button level, so a press in flight at reset is dropped.
            sync_reg     <= 3'b111;
            sel_reg      <= 3'd0;
            tick_reg     <= 1'b0;
            wrap_reg     <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[1:0], step_n};
            prescale_reg <= prescale_next;

            case (state_reg)
                ST_PAUSE: begin
                    if (run) begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end else begin
                        state_reg   <= ST_PAUSE;
                        running_reg <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_reg   <= ST_PAUSE;
                        running_reg <= 1'b0;
                    end else begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= ST_PAUSE;
                    running_reg <= 1'b0;
                end
            endcase

            if (load) begin
                // Load swallows any advance in the same cycle, including
                // its status pulses.
                sel_reg  <= load_sel;
                tick_reg <= 1'b0;
                wrap_reg <= 1'b0;
            end else begin
                tick_reg <= adv;
                wrap_reg <= adv & wrapped;
                if (adv) begin
                    sel_reg <= adv_sel;
                end
            end
        end
    end

    assign sel     = sel_reg;
    assign tick    = tick_reg;
    assign wrap    = wrap_reg;
    assign running = running_reg;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_select_sequencer
//
// Table-driven bench for mux_select_sequencer with a short prescaler
// (DIV_MAX=3, one auto-advance every 4 clocks) plus hand-written sequences
// for load/advance collisions, coincident step and terminal count,
// pause/resume timing and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_mux_select_sequencer;

    logic       clock;
    logic       resetn;
    logic       run;
    logic       step_n;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] sel;
    logic       tick;
    logic       wrap;
    logic       running;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       run;
        logic       step_n;
        logic       dir;
        logic       load;
        logic [2:0] load_val;
        logic [2:0] exp_sel;
        logic       exp_tick;
        logic       exp_wrap;
        logic       exp_running;
    } vec_t;

    vec_t vecs[$];

    mux_select_sequencer #(
        .DIV_WIDTH(4),
        .DIV_MAX  (3),
        .LAST_CODE(4)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .run     (run),
        .step_n  (step_n),
        .dir     (dir),
        .load    (load),
        .load_val(load_val),
        .sel     (sel),
        .tick    (tick),
        .wrap    (wrap),
        .running (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock, then sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] es, input logic et,
                           input logic ew, input logic er);
        chk($sformatf("%s.sel", tag),     8'(sel),     8'(es));
        chk($sformatf("%s.tick", tag),    8'(tick),    8'(et));
        chk($sformatf("%s.wrap", tag),    8'(wrap),    8'(ew));
        chk($sformatf("%s.running", tag), 8'(running), 8'(er));
    endtask

    function automatic void add_vec(input logic r, input logic sn, input logic d,
                                    input logic ld, input logic [2:0] lv,
                                    input logic [2:0] es, input logic et,
                                    input logic ew, input logic er);
        vec_t v;
        v.run = r; v.step_n = sn; v.dir = d; v.load = ld; v.load_val = lv;
        v.exp_sel = es; v.exp_tick = et; v.exp_wrap = ew; v.exp_running = er;
        vecs.push_back(v);
    endfunction

    initial begin
        // ---------------- vector table ----------------
        // Auto up-count from reset: advance every 4th edge, 1,2,3,4,0.
        for (int i = 1; i <= 21; i++) begin
            add_vec(1'b1, 1'b1, 1'b0, 1'b0, 3'd0,
                    3'(((i - 1) / 4) % 5),
                    (i >= 5) && (((i - 1) % 4) == 0),
                    (i == 21),
                    1'b1);
        end
        // Pause.
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        // Manual step down: button held low 6 clocks, sel 0 -> 4 on 3rd edge.
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            add_vec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            add_vec(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
        // Second press: 4 -> 3, tick only.
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            add_vec(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0);
        // Loads with clamp.
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd4, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd4, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        // ---------------- reset and idle ----------------
        resetn = 1'b0; run = 1'b0; step_n = 1'b1; dir = 1'b0;
        load = 1'b0; load_val = 3'd0;
        repeat (3) cyc();
        chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_out($sformatf("idle%0d", i), 3'd0, 1'b0, 1'b0, 1'b0);
        end
        $display("idle: 20 clocks after reset checked");

        // ---------------- apply table ----------------
        foreach (vecs[k]) begin
            run = vecs[k].run; step_n = vecs[k].step_n; dir = vecs[k].dir;
            load = vecs[k].load; load_val = vecs[k].load_val;
            cyc();
            $display("vec %0d: run=%0d step_n=%0d dir=%0d load=%0d/%0d -> sel=%0d tick=%0d wrap=%0d running=%0d",
                     k, run, step_n, dir, load, load_val, sel, tick, wrap, running);
            chk_out($sformatf("vec%0d", k), vecs[k].exp_sel, vecs[k].exp_tick,
                    vecs[k].exp_wrap, vecs[k].exp_running);
        end
        load = 1'b0; step_n = 1'b1; dir = 1'b0;

        // ---------------- load vs auto-advance, prescaler restart ----------------
        run = 1'b1;
        cyc(); chk_out("ld.enter", 3'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_out($sformatf("ld.pre%0d", i), 3'd0, 1'b0, 1'b0, 1'b1);
        end
        load = 1'b1; load_val = 3'd2;           // prescaler at terminal here
        cyc(); chk_out("ld.over_adv", 3'd2, 1'b0, 1'b0, 1'b1);
        load = 1'b0;
        cyc(); chk_out("ld.after", 3'd2, 1'b0, 1'b0, 1'b1);
        load = 1'b1; load_val = 3'd3;           // prescaler at 1 here
        cyc(); chk_out("ld.restart", 3'd3, 1'b0, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_out($sformatf("ld.wait%0d", i), 3'd3, 1'b0, 1'b0, 1'b1);
        end
        cyc(); chk_out("ld.next_adv", 3'd4, 1'b1, 1'b0, 1'b1);
        $display("load sequence: sel=%0d", sel);

        // ---------------- coincident step and terminal count ----------------
        load = 1'b1; load_val = 3'd1;
        cyc(); chk_out("sim.load1", 3'd1, 1'b0, 1'b0, 1'b1);
        load = 1'b0;
        cyc(); chk_out("sim.p1", 3'd1, 1'b0, 1'b0, 1'b1);
        step_n = 1'b0;
        cyc(); chk_out("sim.p2", 3'd1, 1'b0, 1'b0, 1'b1);
        cyc(); chk_out("sim.p3", 3'd1, 1'b0, 1'b0, 1'b1);
        cyc(); chk_out("sim.single", 3'd2, 1'b1, 1'b0, 1'b1);
        step_n = 1'b1;
        cyc(); chk_out("sim.tick_end", 3'd2, 1'b0, 1'b0, 1'b1);
        cyc(); chk_out("sim.hold1", 3'd2, 1'b0, 1'b0, 1'b1);
        cyc(); chk_out("sim.hold2", 3'd2, 1'b0, 1'b0, 1'b1);
        cyc(); chk_out("sim.next_adv", 3'd3, 1'b1, 1'b0, 1'b1);
        $display("coincident sequence: sel=%0d", sel);

        // ---------------- pause at prescaler=2, then resume ----------------
        cyc(); chk_out("pr.p1", 3'd3, 1'b0, 1'b0, 1'b1);
        cyc(); chk_out("pr.p2", 3'd3, 1'b0, 1'b0, 1'b1);
        run = 1'b0;
        cyc(); chk_out("pr.pause", 3'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(); chk_out($sformatf("pr.frozen%0d", i), 3'd3, 1'b0, 1'b0, 1'b0);
        end
        run = 1'b1;
        cyc(); chk_out("pr.resume", 3'd3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_out($sformatf("pr.wait%0d", i), 3'd3, 1'b0, 1'b0, 1'b1);
        end
        cyc(); chk_out("pr.adv", 3'd4, 1'b1, 1'b0, 1'b1);
        $display("pause/resume sequence: sel=%0d", sel);

        // ---------------- asynchronous reset mid-step ----------------
        step_n = 1'b0;
        cyc(); chk_out("ar.pressed", 3'd4, 1'b0, 1'b0, 1'b1);
        #3 resetn = 1'b0;
        #1 chk_out("ar.immediate", 3'd0, 1'b0, 1'b0, 1'b0);
        step_n = 1'b1; run = 1'b0;
        cyc(); chk_out("ar.held", 3'd0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); chk_out($sformatf("ar.discard%0d", i), 3'd0, 1'b0, 1'b0, 1'b0);
        end
        $display("async reset sequence: sel=%0d running=%0d", sel, running);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
- Generates the 3-bit select code for the five-input character multiplexers, replacing static switch selects with a sequenced one.
- Steps the code through 0..LAST_CODE, either automatically at a prescaled rate or manually from a push-button.
- Its sel output drives the mux select bus directly; tick and wrap are status pulses for LEDs and the display rotator.

Parameters:
- DIV_WIDTH, 26, width of the prescaler counter.
- DIV_MAX, 49999999, prescaler terminal count; one auto-advance every DIV_MAX+1 clocks (1 Hz at 50 MHz).
- LAST_CODE, 4, highest legal select code; the sequence is 0..LAST_CODE.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- run  input  1  level; 1 = auto-advance enabled (RUN), 0 = paused (PAUSE).
- step_n  input  1  raw push-button, active-low, asynchronous to clock.
- dir  input  1  0 = count up, 1 = count down.
- load  input  1  synchronous load strobe.
- load_val  input  3  value written to sel when load=1.
- sel  output  3  current select code, registered.
- tick  output  1  one-cycle pulse in the cycle after any advance.
- wrap  output  1  one-cycle pulse in the cycle after an advance that wrapped.
- running  output  1  1 while the FSM is in RUN.

Behaviour:
- Reset (resetn=0, asynchronous) forces:
  - sel=0, tick=0, wrap=0, running=0.
  - FSM=PAUSE, prescaler=0.
  - step_n synchronizer flops s1, s2, s3 all =1, the button idle level.
- Step synchronizer:
  - Each clock: s1<=step_n, s2<=s1, s3<=s2.
  - step_pulse = s3 & ~s2, i.e. exactly one cycle per falling edge.
  - A step_n falling edge with setup before clock edge N advances sel at edge N+2 (the third edge).
  - Holding step_n low produces no further steps. Bounce is not filtered; each clean falling edge counts.
- FSM:
  - PAUSE -> RUN when run=1. RUN -> PAUSE when run=0. Evaluated every edge.
  - running = (FSM==RUN), registered.
- Prescaler:
  - In PAUSE: held at 0.
  - In RUN: increments each clock. At DIV_MAX it returns to 0 and asserts internal auto_adv for that cycle.
  - The first auto-advance after entering RUN occurs DIV_MAX+1 clocks after the transition edge.
- Advance:
  - adv = step_pulse | auto_adv. Step works in both states.
  - Simultaneous step_pulse and auto_adv produce a single advance.
  - Up: sel <= (sel==LAST_CODE) ? 0 : sel+1.
  - Down: sel <= (sel==0) ? LAST_CODE : sel-1.
  - wrapped = (up & sel==LAST_CODE) | (down & sel==0).
- Load:
  - load has priority over adv in the same cycle: sel <= min(load_val, LAST_CODE).
  - Load resets the prescaler to 0. tick and wrap stay 0 for a load.
- Out-of-range codes:
  - If sel is ever > LAST_CODE, the next advance sets sel=0 in either direction.
  - That recovery advance pulses tick but not wrap.
- tick and wrap are registered:
  - tick = adv from the previous cycle, suppressed if load was also high.
  - wrap = wrapped & adv from the previous cycle, suppressed if load was also high.
  - Each is high for exactly one cycle per event.
- dir is sampled on the advancing edge; a dir change never alters sel by itself.
- resetn asserted mid-count or mid-step aborts immediately; the pending step is discarded because the synchronizer resets to 1.

Test Plan:
- Reset then idle: resetn low 3 clocks, then high, all inputs idle -> sel=0, tick=0, wrap=0, running=0 for 20 clocks.
- Auto up-count: DIV_MAX=3, run=1, dir=0 from reset -> sel advances every 4 clocks: 1,2,3,4,0.
  - The 4->0 advance pulses wrap for 1 cycle; tick pulses 5 times; running=1.
- Manual step down: run=0, dir=1, step_n low for 6 clocks from sel=0 -> sel=4 on the 3rd edge only, wrap pulses once.
  - A second press -> sel=3, tick pulses once, wrap=0.
- Load priority and clamp: load=1 with load_val=2 in the same cycle as an auto-advance -> sel=2, tick=0, prescaler restarts.
  - load_val=7 -> sel=4.
- Simultaneous events: step_pulse coincides with the prescaler terminal at sel=1, dir=0 -> sel=2, not 3; tick high exactly 1 cycle.
- Pause/resume and mid-operation reset:
  - Drop run at prescaler=2 -> sel frozen and prescaler=0.
  - Raise run again -> next advance after 4 clocks.
  - Assert resetn between edges -> sel=0 and running=0 immediately, without waiting for a clock edge.
